// File: rtl/bsg_manycore_loader_arbiter.sv
// Round-robin arbiter sharing the manycore loader IO link among num_req_p host requesters,
// routing in-order responses back via an ID FIFO. Optional per-requester grant counters: BSG_MANYCORE_LOADER_ARB_STATS_EN.
module bsg_manycore_loader_arbiter #(
  parameter int num_req_p    = 4,
  parameter int req_width_p  = 32,
  parameter int resp_width_p = 32,
  parameter int max_out_p    = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*req_width_p-1:0] req_data_i,
  output logic [num_req_p-1:0]             req_ready_o,
  output logic [num_req_p-1:0]             resp_v_o,
  output logic [resp_width_p-1:0]          resp_data_o,
  input  logic [num_req_p-1:0]             resp_ready_i,
  output logic                             link_req_v_o,
  output logic [req_width_p-1:0]           link_req_data_o,
  input  logic                             link_req_ready_i,
  input  logic                             link_resp_v_i,
  input  logic [resp_width_p-1:0]          link_resp_data_i,
  output logic                             link_resp_yumi_o,
  output logic                             err_o
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
  ,
  input  logic                             stats_clear_i,
  output logic [num_req_p*32-1:0]          grant_count_o
`endif
);

  localparam int id_width_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int ptr_width_lp = (max_out_p > 1) ? $clog2(max_out_p) : 1;
  localparam int cnt_width_lp = $clog2(max_out_p + 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(max_out_p);

  logic [id_width_lp-1:0]  last_r;
  logic [id_width_lp-1:0]  grant_s;
  logic [id_width_lp-1:0]  head_s;
  logic [id_width_lp-1:0]  id_mem_r [max_out_p];
  logic [ptr_width_lp-1:0] wr_ptr_r;
  logic [ptr_width_lp-1:0] rd_ptr_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    err_r;
  logic                    grant_found_s;
  logic                    not_full_s;
  logic                    not_empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    resp_fire_s;
  logic [req_width_p-1:0]  req_data_s [num_req_p];
  int                      idx_s;

  for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
    assign req_data_s[i] = req_data_i[i*req_width_p +: req_width_p];
  end

  assign not_full_s  = (count_r != full_cnt_lp);
  assign not_empty_s = (count_r != {cnt_width_lp{1'b0}});
  assign head_s      = id_mem_r[rd_ptr_r];

  // Round-robin search starting just above the last granted requester.
  always_comb begin
    grant_found_s = 1'b0;
    grant_s       = last_r;
    idx_s         = 0;
    for (int i = 1; i <= num_req_p; i++) begin
      idx_s = (int'(last_r) + i) % num_req_p;
      if (!grant_found_s && req_v_i[id_width_lp'(idx_s)]) begin
        grant_found_s = 1'b1;
        grant_s       = id_width_lp'(idx_s);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Outputs are forced idle while reset is held, independent of inputs.
  assign link_req_v_o    = reset_n_i & (|req_v_i) & not_full_s;
  assign link_req_data_o = req_data_s[grant_s];
  assign push_s          = link_req_v_o & link_req_ready_i;
  assign req_ready_o     = {num_req_p{push_s}} & (num_req_p'(1) << grant_s);

  // With nothing outstanding a response is swallowed so the link never wedges.
  assign resp_fire_s      = reset_n_i & link_resp_v_i & not_empty_s;
  assign resp_v_o         = {num_req_p{resp_fire_s}} & (num_req_p'(1) << head_s);
  assign resp_data_o      = link_resp_data_i;
  assign link_resp_yumi_o = reset_n_i & link_resp_v_i & (not_empty_s ? resp_ready_i[head_s] : 1'b1);
  assign pop_s            = link_resp_yumi_o & not_empty_s;
  assign err_o            = err_r;

  // Arbitration pointer, ID FIFO pointers, occupancy and sticky error.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_r   <= id_width_lp'(num_req_p - 1);
      wr_ptr_r <= {ptr_width_lp{1'b0}};
      rd_ptr_r <= {ptr_width_lp{1'b0}};
      count_r  <= {cnt_width_lp{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (push_s) begin
        last_r   <= grant_s;
        wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
      if (link_resp_v_i && !not_empty_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // ID storage; written at the tail on every accepted request.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < max_out_p; i++) begin
        id_mem_r[i] <= {id_width_lp{1'b0}};
      end
    end else if (push_s) begin
      id_mem_r[wr_ptr_r] <= grant_s;
    end
  end

`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
  logic [31:0] grant_cnt_r [num_req_p];

  // Saturating accepted-request counters, clearable synchronously.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_req_p; i++) begin
        grant_cnt_r[i] <= 32'd0;
      end
    end else if (stats_clear_i) begin
      for (int i = 0; i < num_req_p; i++) begin
        grant_cnt_r[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (req_ready_o[i] && (grant_cnt_r[i] != 32'hFFFF_FFFF)) begin
          grant_cnt_r[i] <= grant_cnt_r[i] + 32'd1;
        end
      end
    end
  end

  for (genvar i = 0; i < num_req_p; i++) begin : g_stats
    assign grant_count_o[i*32 +: 32] = grant_cnt_r[i];
  end
`endif

endmodule

// File: tb/tb_bsg_manycore_loader_arbiter.sv
// Directed self-checking bench for bsg_manycore_loader_arbiter (4 requesters, 8 outstanding).
module tb_bsg_manycore_loader_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  req_v_i;
  logic [63:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic [3:0]  resp_v_o;
  logic [15:0] resp_data_o;
  logic [3:0]  resp_ready_i;
  logic        link_req_v_o;
  logic [15:0] link_req_data_o;
  logic        link_req_ready_i;
  logic        link_resp_v_i;
  logic [15:0] link_resp_data_i;
  logic        link_resp_yumi_o;
  logic        err_o;
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
  logic        stats_clear_i;
  logic [127:0] grant_count_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  bsg_manycore_loader_arbiter #(
    .num_req_p(4), .req_width_p(16), .resp_width_p(16), .max_out_p(8)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i),
    .link_req_v_o(link_req_v_o), .link_req_data_o(link_req_data_o),
    .link_req_ready_i(link_req_ready_i),
    .link_resp_v_i(link_resp_v_i), .link_resp_data_i(link_resp_data_i),
    .link_resp_yumi_o(link_resp_yumi_o), .err_o(err_o)
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
    , .stats_clear_i(stats_clear_i), .grant_count_o(grant_count_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i        = 1'b0;
    req_v_i          = 4'hF;
    req_data_i       = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    resp_ready_i     = 4'hF;
    link_req_ready_i = 1'b1;
    link_resp_v_i    = 1'b1;
    link_resp_data_i = 16'h0000;
`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
    stats_clear_i    = 1'b0;
`endif
    #2;
    check("rst_req_ready", 32'(req_ready_o), 32'd0);
    check("rst_link_req_v", 32'(link_req_v_o), 32'd0);
    check("rst_resp_v", 32'(resp_v_o), 32'd0);
    check("rst_yumi", 32'(link_resp_yumi_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    req_v_i       = 4'h0;
    link_resp_v_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tick();

    // Round robin with responses one cycle behind
    for (int k = 0; k < 8; k++) begin
      req_v_i          = 4'hF;
      link_resp_v_i    = (k > 0);
      link_resp_data_i = 16'(16'h00B0 + k);
      #1;
      check("rr_grant", 32'(req_ready_o), 32'd1 << (k % 4));
      check("rr_data", 32'(link_req_data_o), 32'h00A0 + 32'(k % 4));
      if (k > 0) begin
        check("rr_resp_v", 32'(resp_v_o), 32'd1 << ((k - 1) % 4));
        check("rr_resp_data", 32'(resp_data_o), 32'h00B0 + 32'(k));
        check("rr_yumi", 32'(link_resp_yumi_o), 32'd1);
      end
      tick();
    end
    req_v_i = 4'h0;
    link_resp_v_i = 1'b1;
    #1;
    check("rr_last_resp", 32'(resp_v_o), 32'd8);
    tick();
    link_resp_v_i = 1'b0;

    // Link stall holds the grant
    req_v_i = 4'b0110;
    link_req_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_v", 32'(link_req_v_o), 32'd1);
      check("stall_ready", 32'(req_ready_o), 32'd0);
      check("stall_data", 32'(link_req_data_o), 32'h00A1);
      tick();
    end
    link_req_ready_i = 1'b1;
    #1;
    check("stall_grant1", 32'(req_ready_o), 32'b0010);
    tick();
    req_v_i = 4'b0100;
    #1;
    check("stall_grant2", 32'(req_ready_o), 32'b0100);
    tick();
    req_v_i = 4'h0;
    link_resp_v_i = 1'b1;
    #1;
    check("stall_resp1", 32'(resp_v_o), 32'b0010);
    tick();
    #1;
    check("stall_resp2", 32'(resp_v_o), 32'b0100);
    tick();
    link_resp_v_i = 1'b0;

    // Fill to max_out_p, then one response frees a slot
    req_v_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("fill_grant", 32'(req_ready_o), 32'd1 << ((3 + k) % 4));
      tick();
    end
    #1;
    check("full_link_v", 32'(link_req_v_o), 32'd0);
    check("full_ready", 32'(req_ready_o), 32'd0);
    link_resp_v_i = 1'b1;
    #1;
    check("full_resp", 32'(resp_v_o), 32'd8);
    check("full_link_v_pop", 32'(link_req_v_o), 32'd0);
    tick();
    link_resp_v_i = 1'b0;
    #1;
    check("ninth_grant", 32'(req_ready_o), 32'd8);
    tick();
    req_v_i = 4'h0;
    link_resp_v_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("drain_order", 32'(resp_v_o), 32'd1 << (k % 4));
      tick();
    end
    #1;
    check("drain_empty", 32'(resp_v_o), 32'd0);
    link_resp_v_i = 1'b0;
    check("drain_err", 32'(err_o), 32'd0);

    // Simultaneous push and pop at count 3
    req_v_i = 4'b0001; #1; check("p3_g0", 32'(req_ready_o), 32'b0001); tick();
    req_v_i = 4'b0010; #1; check("p3_g1", 32'(req_ready_o), 32'b0010); tick();
    req_v_i = 4'b1000; #1; check("p3_g3", 32'(req_ready_o), 32'b1000); tick();
    req_v_i = 4'b0100;
    link_resp_v_i = 1'b1;
    #1;
    check("pp_push", 32'(req_ready_o), 32'b0100);
    check("pp_pop", 32'(resp_v_o), 32'b0001);
    tick();
    req_v_i = 4'h0;
    resp_ready_i = 4'h0;
    #1;
    check("bp_resp_v", 32'(resp_v_o), 32'b0010);
    check("bp_yumi", 32'(link_resp_yumi_o), 32'd0);
    tick();
    resp_ready_i = 4'hF;
    #1; check("pp_order1", 32'(resp_v_o), 32'b0010); tick();
    #1; check("pp_order3", 32'(resp_v_o), 32'b1000); tick();
    #1; check("pp_order2", 32'(resp_v_o), 32'b0100); tick();

    // Stray response on empty FIFO
    #1;
    check("stray_yumi", 32'(link_resp_yumi_o), 32'd1);
    check("stray_resp_v", 32'(resp_v_o), 32'd0);
    check("stray_err_pre", 32'(err_o), 32'd0);
    tick();
    link_resp_v_i = 1'b0;
    #1;
    check("stray_err", 32'(err_o), 32'd1);
    tick();
    check("stray_err_sticky", 32'(err_o), 32'd1);

    // Reset with 5 outstanding
    req_v_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("pre_rst_grant", 32'(req_ready_o), 32'd1 << ((3 + k) % 4));
      tick();
    end
    reset_n_i = 1'b0;
    link_resp_v_i = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    check("mid_rst_link_v", 32'(link_req_v_o), 32'd0);
    check("mid_rst_resp_v", 32'(resp_v_o), 32'd0);
    check("mid_rst_yumi", 32'(link_resp_yumi_o), 32'd0);
    check("mid_rst_err", 32'(err_o), 32'd0);
    tick();
    link_resp_v_i = 1'b0;
    reset_n_i = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready_o), 32'b0001);
    tick();
    req_v_i = 4'h0;
    link_resp_v_i = 1'b1;
    #1;
    check("post_rst_resp", 32'(resp_v_o), 32'b0001);
    tick();
    #1;
    check("post_rst_empty", 32'(resp_v_o), 32'd0);
    check("post_rst_err", 32'(err_o), 32'd0);
    tick();
    link_resp_v_i = 1'b0;

`ifdef BSG_MANYCORE_LOADER_ARB_STATS_EN
    stats_clear_i = 1'b1;
    tick();
    stats_clear_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      req_v_i = 4'b1000;
      link_resp_v_i = (k > 0);
      tick();
    end
    req_v_i = 4'h0;
    link_resp_v_i = 1'b1;
    tick();
    link_resp_v_i = 1'b0;
    #1;
    check("stats_req3", grant_count_o[96 +: 32], 32'd10);
    check("stats_req0", grant_count_o[0 +: 32], 32'd0);
    stats_clear_i = 1'b1;
    tick();
    stats_clear_i = 1'b0;
    check("stats_clear3", grant_count_o[96 +: 32], 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
